fetch_unit: RTL

- Instruction-fetch front end that sits directly upstream of the CPU's IF/ID pipeline register.
- Generates sequential PCs and fetches words from an instruction memory over a req/ack handshake.
- Buffers fetched words in a small prefetch queue and presents {instruction, PC+4} to the decode stage.
- Honours decode stalls and flushes on branch redirect, so the pipeline sees a clean instruction stream or a no-op (all zeros).

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 66 ++++++
 rtl/fetch_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end.
//   NOP_INST      : word presented to decode when no instruction is available
//   fetch_state_e : fetch request FSM states
//   fetch_entry_t : one prefetch-queue entry {instruction, address + 4}
package fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch_entry_t, DEPTH entries (power of two, >= 2).
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush_i      : single-cycle flush; overrides push and pop
//   push_i       : write push_data_i at the tail
//   pop_i        : drop the head entry (ignored when empty)
//   head_o       : current head entry (undefined when empty_o=1)
//   count_o      : number of valid entries, 0..DEPTH
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  fetch_entry_t             push_data_i,
    input  logic                     pop_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end feeding the IF/ID register.
// Issues sequential word fetches over a req/ack handshake (one outstanding
// request), buffers results in a prefetch queue and presents the queue head
// to decode. Branch redirects flush the queue and restart fetching.
//   clk, rst_n          : clock, asynchronous active-low reset
//   imem_req/imem_addr  : fetch request and word-aligned address
//   imem_ack/imem_rdata : one-cycle completion pulse and fetched word
//   stall               : decode cannot take the head this cycle
//   redirect_valid/_pc  : taken branch and its target
//   inst_valid/inst_out/inst_pc_plus4 : queue head to decode (zeros when empty)
//
// state   | meaning
// IDLE    | no request outstanding; waits for queue space
// FETCH   | request for fetch_pc outstanding; ack pushes into the queue
// DISCARD | stale request outstanding after a redirect; its ack is dropped
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc_plus4
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   hold_addr_q, hold_addr_d;

    logic          q_push;
    logic          q_pop;
    logic          q_full;
    logic          q_empty;
    logic [CW-1:0] q_count;
    logic [CW-1:0] cnt_after;
    fetch_entry_t  q_head;
    fetch_entry_t  push_data;

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_valid),
        .push_i      (q_push),
        .push_data_i (push_data),
        .pop_i       (q_pop),
        .head_o      (q_head),
        .count_o     (q_count),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

    // The request line is a pure function of state, so reset drops it at once.
    assign imem_req  = (state_q == FETCH) || (state_q == DISCARD);
    assign imem_addr = (state_q == DISCARD) ? hold_addr_q : fetch_pc_q;

    assign q_pop     = !q_empty && !stall;
    assign q_push    = (state_q == FETCH) && imem_ack && !redirect_valid;
    assign push_data = '{inst: imem_rdata, pc_plus4: fetch_pc_q + 32'd4};

    // Occupancy after this cycle's ack push and any pop.
    assign cnt_after = q_count + CW'(1) - CW'(q_pop);

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        hold_addr_d = hold_addr_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            case (state_q)
                FETCH: begin
                    if (imem_ack) begin
                        state_d = FETCH;
                    end else begin
                        state_d     = DISCARD;
                        hold_addr_d = fetch_pc_q;
                    end
                end
                // The stale request keeps its original address until it completes.
                DISCARD: state_d = imem_ack ? FETCH : DISCARD;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (q_count < CW'(DEPTH)) state_d = FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = (cnt_after < CW'(DEPTH)) ? FETCH : IDLE;
                    end
                end
                DISCARD: begin
                    if (imem_ack) state_d = FETCH;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            hold_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            hold_addr_q <= hold_addr_d;
        end
    end

    assign inst_valid    = !q_empty;
    assign inst_out      = q_empty ? NOP_INST : q_head.inst;
    assign inst_pc_plus4 = q_empty ? 32'h0 : q_head.pc_plus4;

    // Requests are only issued with room in the queue, so an ack can never meet a full queue.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == FETCH && imem_ack) |-> !q_full);

endmodule
